// File: rtl/addon_pkg.sv
// Shared types and constants for the leg solver and its squarer.
package addon_pkg;

  localparam int unsigned ADDON_W = 8;

  // Last iteration index of the W-step squarer and square-root loops.
  localparam int unsigned ADDON_ITER_LAST = ADDON_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_R,
    ST_MUL_X,
    ST_DIFF,
    ST_ROOT,
    ST_DONE
  } addon_state_e;

  // Iteration-count constant for an arbitrary width.
  function automatic int unsigned iter_last(input int unsigned w);
    return w - 1;
  endfunction

endpackage

// File: rtl/addon_sqmul.sv
// W x W shift-add squarer, LSB first, one partial product per cycle.
// start loads the operand; done is high during the cycle whose edge
// performs the final add, and product carries that final sum.
module addon_sqmul
  import addon_pkg::*;
#(
  parameter int unsigned W = ADDON_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  input  logic [W-1:0]   a,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(iter_last(W));

  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] sum;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // Accumulator plus the current partial product.
  always_comb begin
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done    = ena && busy_q && (cnt_q == CNT_LAST);
  assign product = sum;

  // Shift-add step; a start on the final step's edge reloads for the next
  // operand, since the finished product is consumed combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (ena) begin
      if (busy_q) begin
        acc_q    <= sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
        end
      end
      if (start) begin
        mcand_q  <= {{W{1'b0}}, a};
        mplier_q <= a;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/addon_leg_solver.sv
// Computes y = floor(sqrt(r^2 - x^2)) with a shared serial squarer and a
// bit-serial square root, behind valid/ready handshakes on both sides.
module addon_leg_solver
  import addon_pkg::*;
#(
  parameter int unsigned W = ADDON_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic         err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] IT_LAST = CW'(iter_last(W));

  addon_state_e state_q, state_d;

  logic [W-1:0]   x_q;
  logic [2*W-1:0] rsq_q;
  logic [2*W-1:0] xsq_q;
  logic [2*W-1:0] d_q;
  logic [W+1:0]   rem_q;
  logic [W-1:0]   root_q;
  logic [CW-1:0]  it_q;
  logic           err_q;

  logic           sq_start;
  logic [W-1:0]   sq_a;
  logic           sq_done;
  logic [2*W-1:0] sq_prod;

  logic           accept;
  logic           root_last;
  logic           out_fire;

  logic [W+1:0]   rem_sh;
  logic [W+1:0]   trial;
  logic           trial_ok;
  logic [W+1:0]   rem_nx;
  logic [W-1:0]   root_nx;

  // r is squared straight from the input port on the accept edge; x is
  // held in x_q and fed in on the edge where r^2 completes.
  addon_sqmul #(
    .W(W)
  ) u_sqmul (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (sq_start),
    .a      (sq_a),
    .done   (sq_done),
    .product(sq_prod)
  );

  // One square-root step: bring down two radicand bits and try to subtract.
  always_comb begin
    rem_sh   = {rem_q[W-1:0], d_q[2*W-1 -: 2]};
    trial    = {root_q, 2'b01};
    trial_ok = (rem_sh >= trial);
    rem_nx   = trial_ok ? (rem_sh - trial) : rem_sh;
    root_nx  = {root_q[W-2:0], trial_ok};
  end

  // Next-state, handshake and squarer control.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sq_start  = 1'b0;
    sq_a      = x_q;
    accept    = 1'b0;
    root_last = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = ena;
        sq_a     = r_in;
        if (ena && in_valid) begin
          accept   = 1'b1;
          sq_start = 1'b1;
          state_d  = ST_MUL_R;
        end
      end
      ST_MUL_R: begin
        if (sq_done) begin
          sq_start = 1'b1;
          state_d  = ST_MUL_X;
        end
      end
      ST_MUL_X: begin
        if (sq_done) begin
          state_d = ST_DIFF;
        end
      end
      ST_DIFF: begin
        if (ena) begin
          state_d = ST_ROOT;
        end
      end
      ST_ROOT: begin
        if (ena && (it_q == IT_LAST)) begin
          root_last = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ena && out_valid && out_ready) begin
          out_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand capture, squares, difference, root, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      rsq_q     <= '0;
      xsq_q     <= '0;
      d_q       <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      it_q      <= '0;
      err_q     <= 1'b0;
      y_out     <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q <= x_in;
          end
        end
        ST_MUL_R: begin
          if (sq_done) begin
            rsq_q <= sq_prod;
          end
        end
        ST_MUL_X: begin
          if (sq_done) begin
            xsq_q <= sq_prod;
          end
        end
        ST_DIFF: begin
          if (xsq_q > rsq_q) begin
            err_q <= 1'b1;
            d_q   <= '0;
          end else begin
            err_q <= 1'b0;
            d_q   <= rsq_q - xsq_q;
          end
          rem_q  <= '0;
          root_q <= '0;
          it_q   <= '0;
        end
        ST_ROOT: begin
          rem_q  <= rem_nx;
          root_q <= root_nx;
          d_q    <= d_q << 2;
          it_q   <= it_q + 1'b1;
          if (root_last) begin
            y_out     <= root_nx;
            err       <= err_q;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addon_leg_solver.sv
// Self-checking bench for addon_leg_solver against an arithmetic model.
module tb_addon_leg_solver;

  localparam int W   = 8;
  localparam int LAT = 3 * W + 1;
  localparam int PER = 3 * W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] r_in = '0;
  logic [W-1:0] x_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y_out;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addon_leg_solver #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .r_in     (r_in),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .err      (err)
  );

  // Reference: err when x > r, else the largest y with y*y <= r*r - x*x.
  function automatic void model(input int r, input int x, output int y, output int e);
    int d;
    y = 0;
    e = 0;
    if (x > r) begin
      e = 1;
      return;
    end
    d = r * r - x * x;
    while ((y + 1) * (y + 1) <= d) y++;
  endfunction

  // Present operands and complete one input handshake.
  task automatic start_op(input int r, input int x);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    r_in = W'(r);
    x_in = W'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%0d err=%b, expected 1 0 0 0",
               in_ready, out_valid, y_out, err);
    end
  endtask

  task automatic test_directed();
    int vr[9] = '{5, 13, 255, 10, 200, 3, 0, 255, 1};
    int vx[9] = '{3, 12, 0, 1, 200, 5, 0, 255, 0};
    int lat, ey, ee;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      model(vr[i], vx[i], ey, ee);
      start_op(vr[i], vx[i]);
      wait_out(lat);
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed_latency r=%0d x=%0d: got %0d, expected %0d", vr[i], vx[i], lat, LAT);
      end
      n_checks++;
      if (int'(y_out) !== ey || int'(err) !== ee) begin
        n_fail++;
        $display("FAIL directed_result r=%0d x=%0d: got y=%0d err=%0d, expected y=%0d err=%0d",
                 vr[i], vx[i], y_out, err, ey, ee);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    int r, x, lat, ey, ee;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(0, 255));
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, r));
      model(r, x, ey, ee);
      start_op(r, x);
      wait_out(lat);
      n_checks++;
      if (lat !== LAT || int'(y_out) !== ey || int'(err) !== ee) begin
        n_fail++;
        $display("FAIL random r=%0d x=%0d: got lat=%0d y=%0d err=%0d, expected lat=%0d y=%0d err=%0d",
                 r, x, lat, y_out, err, LAT, ey, ee);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int lat, seen;
    out_ready = 1'b0;
    start_op(13, 5);
    wait_out(lat);
    n_checks++;
    if (lat !== LAT || y_out !== 8'd12 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_result: got lat=%0d y=%0d err=%b, expected lat=%0d y=12 err=0", lat, y_out, err, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      r_in = 8'd7;
      x_in = 8'd2;
      @(posedge clk);
      #1;
      n_checks++;
      if (y_out !== 8'd12 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: y=%0d out_valid=%b in_ready=%b, expected 12 1 0",
                 i, y_out, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bp_ignored_input: out_valid high for %0d cycles, expected 0", seen);
    end
  endtask

  task automatic test_stall();
    int n, bad;
    out_ready = 1'b1;
    start_op(10, 1);
    n = 0;
    bad = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 19) ena = 1'b0;
      if (!ena && (in_ready !== 1'b0 || out_valid !== 1'b0)) bad++;
      if (n == 23) ena = 1'b1;
    end while (!out_valid && n < 100);
    n_checks++;
    if (n !== LAT + 4 || y_out !== 8'd9 || err !== 1'b0 || bad !== 0) begin
      n_fail++;
      $display("FAIL stall: got lat=%0d y=%0d err=%b bad=%0d, expected lat=%0d y=9 err=0 bad=0",
               n, y_out, err, bad, LAT + 4);
    end
    @(posedge clk);
    #1;
    ena = 1'b0;
    in_valid = 1'b1;
    r_in = 8'd5;
    x_in = 8'd3;
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    ena = 1'b1;
    #1;
    n_checks++;
    if (bad !== 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_disabled: bad=%0d in_ready=%b, expected 0 1", bad, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    start_op(200, 56);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (y_out !== '0 || err !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: y=%0d err=%b out_valid=%b, expected 0 0 0", y_out, err, out_valid);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: in_ready=%b, expected 1", in_ready);
    end
    start_op(5, 4);
    wait_out(lat);
    n_checks++;
    if (lat !== LAT || y_out !== 8'd3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: got lat=%0d y=%0d err=%b, expected lat=%0d y=3 err=0", lat, y_out, err, LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int ey_q[$];
    int ee_q[$];
    int cyc = 0, prev = -1, n_acc = 0, n_out = 0;
    int ey, ee;
    out_ready = 1'b1;
    r_in = W'($urandom);
    x_in = W'($urandom_range(0, 255));
    in_valid = 1'b1;
    while (n_out < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        n_checks++;
        if (ey_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_output: y=%0d err=%b, expected no output", y_out, err);
        end else begin
          ey = ey_q.pop_front();
          ee = ee_q.pop_front();
          if (int'(y_out) !== ey || int'(err) !== ee) begin
            n_fail++;
            $display("FAIL b2b_result: got y=%0d err=%0d, expected y=%0d err=%0d", y_out, err, ey, ee);
          end
        end
        n_out++;
      end
      if (in_ready) begin
        if (n_acc < 4) begin
          model(int'(r_in), int'(x_in), ey, ee);
          ey_q.push_back(ey);
          ee_q.push_back(ee);
          if (prev >= 0) begin
            n_checks++;
            if (cyc - prev !== PER) begin
              n_fail++;
              $display("FAIL b2b_period: got %0d, expected %0d", cyc - prev, PER);
            end
          end
          prev = cyc;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        r_in = W'($urandom);
        x_in = W'($urandom);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs, expected 4", n_out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addon_leg_solver.md
# addon_leg_solver

Sequential inverse of the hypotenuse datapath: given a hypotenuse `r` and one leg `x`, it computes the other leg `y = floor(sqrt(r² − x²))`. It replaces wide combinational multipliers and square-root logic with one shift-add squarer and a bit-serial square root. Operands enter through a valid/ready handshake and results leave through a second one, so the block can sit behind the Tiny Tapeout pin wrapper or any internal stream source.

## Interface
Parameters:
- `W`, 8: operand and result width; squares and the difference are 2W bits.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: global enable; low freezes all state.
- `in_valid` in 1: `r_in` and `x_in` are valid.
- `in_ready` out 1: block can accept operands.
- `r_in` in W: hypotenuse.
- `x_in` in W: known leg.
- `out_valid` out 1: `y_out` and `err` are valid.
- `out_ready` in 1: consumer accepts the result.
- `y_out` out W: computed leg.
- `err` out 1: set when `x > r`.

## Operation
- FSM states: IDLE → MUL_R → MUL_X → DIFF → ROOT → DONE → IDLE.
- IDLE:
  - `in_ready = 1` while `ena` is high.
  - On `in_valid & in_ready`, latch `r_in` and `x_in`, then go to MUL_R.
- MUL_R: W cycles of shift-add (LSB first), producing `r²` (2W bits). Then go to MUL_X.
- MUL_X: W cycles on the same squarer, producing `x²`. Then go to DIFF.
- DIFF: one cycle.
  - If `x² > r²`: `err = 1` and the radicand is forced to 0.
  - Otherwise: `err = 0` and radicand `D = r² − x²`.
- ROOT: W iterations of the non-restoring integer square root, one per cycle.
  - Update: `rem = (rem << 2) | next two MSBs of D`; `t = (root << 2) | 1`.
  - If `rem ≥ t`: `rem −= t` and `root = (root << 1) | 1`. Else: `root <<= 1`.
  - `rem` is W+2 bits.
  - After the last iteration, register the result in `y_out`, set `out_valid`, go to DONE.
- DONE:
  - `y_out`, `err` and `out_valid` hold stable.
  - On `out_valid & out_ready & ena`: clear `out_valid`, go to IDLE.
- Latency is fixed and independent of the operands, including the `err` case.
- `in_valid` outside IDLE is ignored; operands are not queued.
- `ena = 0`:
  - Every register holds its value.
  - `in_ready` is forced to 0.
  - No handshake completes in either direction; `out_valid` stays asserted if already set.
- Asynchronous reset at any time, including mid-computation: state goes to IDLE and every register clears. The in-flight operation is discarded with no output.

## Timing
- Reset values: `in_ready = 1` (given `ena = 1`), `out_valid = 0`, `y_out = 0`, `err = 0`.
- Latency: an input handshake at edge k makes `out_valid` high after edge k+3W+1 (k+25 for W = 8).
- `in_ready` falls after edge k and returns after the edge where the output handshake completes.
- Maximum throughput: one result per 3W+3 cycles, reached with `out_ready` held high.
- Each cycle with `ena` low adds exactly one cycle of latency.
- `y_out` and `err` are registered; they only change when `out_valid` rises or at reset.

## Structure
- Package `addon_pkg` holds:
  - the state enum;
  - the default width `ADDON_W = 8`;
  - the iteration-count constant W−1 (counter width `$clog2(W)`).
- One sub-module, `addon_sqmul`: a W×W shift-add squarer with `start`/`done` and a 2W-bit product. It is instantiated once and reused for MUL_R and MUL_X.
- The square-root iteration and the FSM live in `addon_leg_solver`.

## Test plan
- `r=5, x=3`, `out_ready=1` → `y_out=4`, `err=0`, `out_valid` exactly 25 cycles after the accept edge; `r=13, x=12` → 5; `r=255, x=0` → 255.
- Flooring: `r=10, x=1` (radicand 99) → `y_out=9`; `r=200, x=200` → `y_out=0`, `err=0`.
- Error case: `r=3, x=5` → `y_out=0`, `err=1`, latency still 25.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid` rises → `y_out` stable and `in_ready=0` throughout; a new `in_valid` during that window is ignored; handshake completes on the first `out_ready=1` cycle.
- Stall: `ena=0` for 4 cycles during ROOT → result unchanged, `out_valid` at 29 cycles.
- Reset mid-operation: `rst_n` asserted 10 cycles after accept → outputs immediately 0, `in_ready=1` after release, and the next operation (`r=5, x=4` → 3) is correct.
